mem_slice_requester: RTL and testbench

Initiator-side engine for one memory-slice port: accepts a block command (base address, word count, read/write), issues the per-word requests on the slice's target handshake, and returns read data in order on an output stream. It sits between a sequencer/DMA front end and any slice port, whether the port has 1-cycle or 2-cycle response latency. Completion depends only on handshakes, never on port latency. A credit counter bounds outstanding reads to the depth of a local response FIFO, so responses never back-pressure the slice.

---
 rtl/mem_slice_requester_if.sv | 59 +++++
 rtl/mem_slice_requester.sv | 191 +++++++++++++++++++
 tb/tb_mem_slice_requester.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_slice_requester_if.sv
// rtl/mem_slice_requester_if.sv - command, slice request/response, write-data and read-data bundle
interface mem_slice_requester_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_write;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_we;

    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_write,
        output cmd_ready,
        output m_valid, m_addr, m_data, m_we,
        input  m_ready,
        input  r_valid, r_addr, r_data,
        output r_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        output rd_valid, rd_data, rd_addr, rd_last,
        input  rd_ready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_write,
        input  cmd_ready,
        input  m_valid, m_addr, m_data, m_we,
        output m_ready,
        output r_valid, r_addr, r_data,
        input  r_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        input  rd_valid, rd_data, rd_addr, rd_last,
        output rd_ready
    );
endinterface

// File: rtl/mem_slice_requester.sv
// rtl/mem_slice_requester.sv - block command engine for one memory-slice port
// Optional response address checking: RSP_ADDR_CHECK_EN
module mem_slice_requester #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 13,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_slice_requester_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [LEN_W-1:0]  ret_remain_q, ret_remain_d;
    logic              write_q, write_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              idle_q, idle_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [RSP_DEPTH];
    logic              fifo_last_q [RSP_DEPTH];

    logic run_rd, run_wr, credit_ok, fifo_full;
    logic m_fire, r_fire, r_push, rd_fire;

    assign run_rd    = (state_q == RUN) && !write_q;
    assign run_wr    = (state_q == RUN) && write_q;
    // Credits cover both in-flight reads and words already buffered, so the FIFO can never overflow.
    assign credit_ok = (outst_q + cnt_q) < DEPTH_C;
    assign fifo_full = (cnt_q == DEPTH_C);

    assign bus.cmd_ready = idle_q & reset_n;
    assign bus.m_valid   = run_wr ? bus.wd_valid : (run_rd & credit_ok);
    assign bus.m_addr    = addr_q;
    assign bus.m_data    = run_wr ? bus.wd_data : '0;
    assign bus.m_we      = write_q;
    assign bus.wd_ready  = run_wr & bus.m_ready;
    assign bus.r_ready   = !fifo_full;
    assign bus.rd_valid  = (cnt_q != '0);
    assign bus.rd_data   = fifo_data_q[rd_ptr_q];
    assign bus.rd_addr   = fifo_addr_q[rd_ptr_q];
    assign bus.rd_last   = bus.rd_valid & fifo_last_q[rd_ptr_q];

    assign m_fire  = bus.m_valid & bus.m_ready;
    assign r_fire  = bus.r_valid & bus.r_ready;
    // Stray responses (nothing outstanding) are consumed but never buffered.
    assign r_push  = r_fire && (outst_q != '0);
    assign rd_fire = bus.rd_valid & bus.rd_ready;

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        ret_remain_d = ret_remain_q;
        write_d      = write_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        outst_d      = outst_q + CW'(m_fire & !write_q) - CW'(r_push);
        cnt_d        = cnt_q + CW'(r_push) - CW'(rd_fire);

        if (m_fire) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - LEN_W'(1);
        end
        if (r_push) begin
            ret_remain_d = ret_remain_q - LEN_W'(1);
            wr_ptr_d     = wr_ptr_q + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d       = bus.cmd_addr;
                    remain_d     = bus.cmd_len;
                    ret_remain_d = bus.cmd_write ? '0 : bus.cmd_len;
                    write_d      = bus.cmd_write;
                    state_d      = (bus.cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (m_fire && (remain_q == LEN_W'(1))) begin
                    state_d = write_q ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (rd_fire && bus.rd_last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        idle_d = (state_d == IDLE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            ret_remain_q <= '0;
            write_q      <= 1'b0;
            outst_q      <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            idle_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            ret_remain_q <= ret_remain_d;
            write_q      <= write_d;
            outst_q      <= outst_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            idle_q       <= idle_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // The final response of the command is tagged as it enters the FIFO.
    always_ff @(posedge clk) begin
        if (r_push) begin
            fifo_data_q[wr_ptr_q] <= bus.r_data;
            fifo_addr_q[wr_ptr_q] <= bus.r_addr;
            fifo_last_q[wr_ptr_q] <= (ret_remain_q == LEN_W'(1));
        end
    end

`ifdef RSP_ADDR_CHECK_EN
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              err_q, err_d;

    always_comb begin
        exp_addr_d = exp_addr_q;
        err_d      = err_q;
        if ((state_q == IDLE) && bus.cmd_valid) begin
            exp_addr_d = bus.cmd_addr;
        end
        if (r_push) begin
            exp_addr_d = exp_addr_q + ADDR_W'(1);
        end
        if (r_fire && ((outst_q == '0) || (bus.r_addr != exp_addr_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            exp_addr_q <= exp_addr_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_slice_requester.sv
// tb/tb_mem_slice_requester.sv - directed self-checking bench for mem_slice_requester
module tb_mem_slice_requester;
    logic clk;
    logic reset_n;
    logic busy, done, err;

    mem_slice_requester_if #(.ADDR_W(12), .DATA_W(32), .LEN_W(13)) bus();

    mem_slice_requester #(.ADDR_W(12), .DATA_W(32), .LEN_W(13), .RSP_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          lat       = 1;
    bit          inj_en    = 0;
    logic [11:0] inj_match = 12'h000;

    int          busy_cnt, mval_cnt, done_cnt, done_cyc, rvalid_cnt, refuse_cnt, err_rise;
    int          inflight, max_inflight;
    int          iss_n, wr_n, rd_n;
    logic [11:0] iss_a [64];
    int          iss_c [64];
    logic [11:0] wr_a  [64];
    logic [31:0] wr_d  [64];
    int          wr_c  [64];
    logic [31:0] rd_d  [64];
    logic [11:0] rd_a  [64];
    logic        rd_l  [64];
    int          rd_c  [64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached, exp completion");
        $fatal(1, "watchdog");
    end

    // Slice responder: 1- or 2-cycle read latency, data derived from address.
    initial begin
        logic        req_c, s1_v, nv;
        logic [11:0] req_a, s1_a, na;
        s1_v = 1'b0;
        s1_a = '0;
        bus.r_valid = 1'b0;
        bus.r_addr  = '0;
        bus.r_data  = '0;
        forever begin
            @(negedge clk);
            req_c = reset_n && bus.m_valid && bus.m_ready && !bus.m_we;
            req_a = bus.m_addr;
            if (!reset_n) s1_v = 1'b0;
            @(posedge clk);
            #1;
            if (lat == 2) begin
                nv = s1_v; na = s1_a; s1_v = req_c; s1_a = req_a;
            end else begin
                nv = req_c; na = req_a;
            end
            bus.r_valid = nv;
            bus.r_data  = 32'hC0DE_0000 | {20'h0, na};
            bus.r_addr  = (inj_en && na == inj_match) ? 12'h123 : na;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (busy) busy_cnt++;
            if (bus.m_valid) mval_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (bus.r_valid) rvalid_cnt++;
            if (bus.r_valid && !bus.r_ready) refuse_cnt++;
            if (err && err_rise < 0) err_rise = cyc;
            if (bus.m_valid && bus.m_ready && !bus.m_we) begin
                if (iss_n < 64) begin iss_a[iss_n] = bus.m_addr; iss_c[iss_n] = cyc; end
                iss_n++;
                inflight++;
            end
            if (bus.m_valid && bus.m_ready && bus.m_we) begin
                if (wr_n < 64) begin wr_a[wr_n] = bus.m_addr; wr_d[wr_n] = bus.m_data; wr_c[wr_n] = cyc; end
                wr_n++;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (rd_n < 64) begin
                    rd_d[rd_n] = bus.rd_data; rd_a[rd_n] = bus.rd_addr;
                    rd_l[rd_n] = bus.rd_last; rd_c[rd_n] = cyc;
                end
                rd_n++;
                inflight--;
            end
            if (inflight > max_inflight) max_inflight = inflight;
        end
    end

    task automatic clear_logs();
        busy_cnt = 0; mval_cnt = 0; done_cnt = 0; done_cyc = -1;
        rvalid_cnt = 0; refuse_cnt = 0; err_rise = -1;
        inflight = 0; max_inflight = 0;
        iss_n = 0; wr_n = 0; rd_n = 0;
    endtask

    task automatic send_cmd(input logic [11:0] a, input logic [12:0] l, input logic w, output int acc);
        acc = -1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_write = w;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin acc = cyc; break; end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        checks++;
        if (acc < 0) begin errors++; $display("FAIL cmd_accept got no cmd_ready exp accept"); end
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (!seen) begin errors++; $display("FAIL done_timeout got none in %0d cycles exp done", limit); end
    endtask

    task automatic check_reads(input string tag, input logic [11:0] base, input int n);
        logic [31:0] ed;
        logic [11:0] ea;
        checks++;
        if (rd_n !== n) begin errors++; $display("FAIL %s rd_count got %0d exp %0d", tag, rd_n, n); end
        for (int i = 0; i < n; i++) begin
            ea = 12'(base + 12'(i));
            ed = 32'hC0DE_0000 | {20'h0, ea};
            checks++;
            if (rd_d[i] !== ed) begin errors++; $display("FAIL %s rd_data[%0d] got %h exp %h", tag, i, rd_d[i], ed); end
            checks++;
            if (rd_l[i] !== (i == n - 1)) begin errors++; $display("FAIL %s rd_last[%0d] got %b exp %b", tag, i, rd_l[i], (i == n - 1)); end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.m_valid, bus.wd_ready, bus.rd_valid, bus.rd_last, busy, done, err, bus.r_ready} !== 9'b000000001) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000000001",
                     {bus.cmd_ready, bus.m_valid, bus.wd_ready, bus.rd_valid, bus.rd_last, busy, done, err, bus.r_ready});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_basic();
        int acc;
        clear_logs();
        lat = 1;
        bus.rd_ready = 1'b1;
        send_cmd(12'h010, 13'd8, 1'b0, acc);
        wait_done(100);
        checks++;
        if (iss_n !== 8) begin errors++; $display("FAIL rb_issue_count got %0d exp 8", iss_n); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (iss_a[i] !== 12'(12'h010 + 12'(i)) || iss_c[i] !== acc + 1 + i) begin
                errors++;
                $display("FAIL rb_issue[%0d] got addr %h cyc %0d exp addr %h cyc %0d", i, iss_a[i], iss_c[i], 12'(12'h010 + 12'(i)), acc + 1 + i);
            end
        end
        check_reads("rb", 12'h010, 8);
        checks++;
        if (done_cnt !== 1 || done_cyc !== rd_c[7] + 1) begin
            errors++;
            $display("FAIL rb_done got count %0d cyc %0d exp count 1 cyc %0d", done_cnt, done_cyc, rd_c[7] + 1);
        end
    endtask

    task automatic test_write_wrap();
        int acc;
        bit got;
        logic [11:0] wexp [4];
        wexp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        clear_logs();
        send_cmd(12'hFFE, 13'd4, 1'b1, acc);
        for (int i = 0; i < 4; i++) begin
            bus.wd_valid = 1'b0;
            @(posedge clk);
            #1;
            bus.wd_valid = 1'b1;
            bus.wd_data  = 32'hA0 + 32'(i);
            got = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.wd_ready) begin got = 1; break; end
            end
            @(posedge clk);
            #1;
            checks++;
            if (!got) begin errors++; $display("FAIL ww_wd_ready[%0d] got none exp handshake", i); end
        end
        bus.wd_valid = 1'b0;
        wait_done(20);
        checks++;
        if (wr_n !== 4) begin errors++; $display("FAIL ww_count got %0d exp 4", wr_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_a[i] !== wexp[i] || wr_d[i] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL ww_write[%0d] got %h/%h exp %h/%h", i, wr_a[i], wr_d[i], wexp[i], 32'hA0 + 32'(i));
            end
        end
        checks++;
        if (rvalid_cnt !== 0) begin errors++; $display("FAIL ww_rvalid got %0d exp 0", rvalid_cnt); end
        checks++;
        if (done_cnt !== 1 || done_cyc !== wr_c[3] + 1) begin
            errors++;
            $display("FAIL ww_done got count %0d cyc %0d exp count 1 cyc %0d", done_cnt, done_cyc, wr_c[3] + 1);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        clear_logs();
        lat = 2;
        bus.rd_ready = 1'b0;
        send_cmd(12'h300, 13'd16, 1'b0, acc);
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (iss_n !== 4) begin errors++; $display("FAIL bp_stall_issues got %0d exp 4", iss_n); end
        bus.rd_ready = 1'b1;
        wait_done(200);
        checks++;
        if (iss_n !== 16) begin errors++; $display("FAIL bp_issue_count got %0d exp 16", iss_n); end
        checks++;
        if (max_inflight > 4) begin errors++; $display("FAIL bp_outstanding got %0d exp <=4", max_inflight); end
        checks++;
        if (refuse_cnt !== 0) begin errors++; $display("FAIL bp_r_ready_refusals got %0d exp 0", refuse_cnt); end
        check_reads("bp", 12'h300, 16);
        lat = 1;
    endtask

    task automatic test_zero_len();
        int acc;
        clear_logs();
        send_cmd(12'h050, 13'd0, 1'b0, acc);
        wait_done(20);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (mval_cnt !== 0) begin errors++; $display("FAIL zl_m_valid got %0d exp 0", mval_cnt); end
        checks++;
        if (busy_cnt !== 1) begin errors++; $display("FAIL zl_busy_cycles got %0d exp 1", busy_cnt); end
        checks++;
        if (done_cnt !== 1 || done_cyc !== acc + 1) begin
            errors++;
            $display("FAIL zl_done got count %0d cyc %0d exp count 1 cyc %0d", done_cnt, done_cyc, acc + 1);
        end
    endtask

    task automatic test_addr_check();
        int acc;
        clear_logs();
        lat = 1;
        inj_en = 1;
        inj_match = 12'h011;
        bus.rd_ready = 1'b1;
        send_cmd(12'h010, 13'd4, 1'b0, acc);
        wait_done(100);
        inj_en = 0;
        check_reads("ac", 12'h010, 4);
        checks++;
        if (rd_a[1] !== 12'h123 || rd_a[2] !== 12'h012) begin
            errors++;
            $display("FAIL ac_rd_addr got %h,%h exp 123,012", rd_a[1], rd_a[2]);
        end
`ifdef RSP_ADDR_CHECK_EN
        checks++;
        if (err_rise !== acc + 4) begin errors++; $display("FAIL ac_err_rise got %0d exp %0d", err_rise, acc + 4); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL ac_err_sticky got %b exp 1", err); end
`else
        checks++;
        if (err_rise !== -1 || err !== 1'b0) begin errors++; $display("FAIL ac_err_tied got rise %0d err %b exp -1/0", err_rise, err); end
`endif
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_logs();
        lat = 1;
        bus.rd_ready = 1'b1;
        send_cmd(12'h100, 13'd32, 1'b0, acc);
        repeat (10) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_cmd_ready_in_reset got %b exp 0", bus.cmd_ready); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.m_valid, bus.wd_ready, bus.rd_valid, bus.rd_last, busy, done, err, bus.r_ready} !== 9'b100000001) begin
            errors++;
            $display("FAIL rm_outputs got %b exp 100000001",
                     {bus.cmd_ready, bus.m_valid, bus.wd_ready, bus.rd_valid, bus.rd_last, busy, done, err, bus.r_ready});
        end
        @(posedge clk);
        #1;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL rm_no_done got %0d exp 0", done_cnt); end
        clear_logs();
        send_cmd(12'h200, 13'd2, 1'b0, acc);
        wait_done(50);
        check_reads("rm", 12'h200, 2);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL rm_done_count got %0d exp 1", done_cnt); end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_write = 1'b0;
        bus.m_ready   = 1'b1;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.rd_ready  = 1'b1;
        clear_logs();
        test_reset();
        test_read_basic();
        test_write_wrap();
        test_backpressure();
        test_zero_len();
        test_addr_check();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
